// File: rtl/audio_buffer_ctrl.sv
// Record/playback sequencer owning both ports of the audio BRAM: records incoming
// samples through port B and replays them through port A at the playback tick rate.
module audio_buffer_ctrl #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 40_000,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  record_in,
    input  logic                  play_in,
    input  logic                  stop_in,
    input  logic                  loop_in,
    input  logic [WIDTH-1:0]      sample_in,
    input  logic                  sample_valid_in,
    input  logic                  tick_in,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [WIDTH-1:0]      wr_data_out,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    input  logic [WIDTH-1:0]      rd_data_in,
    output logic [WIDTH-1:0]      sample_out,
    output logic                  sample_valid_out,
    output logic [ADDR_WIDTH:0]   length_out,
    output logic [1:0]            state_out,
    output logic                  busy_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECORD = 2'd1;
    localparam logic [1:0] PLAY   = 2'd2;

    localparam logic [ADDR_WIDTH:0] LAST_WR_LEN = (ADDR_WIDTH+1)'(DEPTH - 1);

    logic [1:0]              state;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic                    issue_done;
    logic [READ_LATENCY:0]   valid_pipe;
    logic [READ_LATENCY:0]   last_pipe;
    logic [ADDR_WIDTH:0]     next_rd_count;
    logic                    is_last_idx;
    logic                    tick_issue;
    logic                    last_issue;
    logic                    discard;

    assign next_rd_count = {1'b0, rd_ptr} + (ADDR_WIDTH+1)'(1);
    assign is_last_idx   = (next_rd_count == length_out);
    assign discard       = (state == PLAY) && stop_in;
    assign tick_issue    = (state == PLAY) && tick_in && !issue_done && !stop_in;
    // last_pipe rides alongside valid_pipe so the final pulse can drop us back to IDLE.
    assign last_issue    = tick_issue && is_last_idx && !loop_in;

    assign state_out = state;
    assign busy_out  = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            rd_ptr           <= '0;
            issue_done       <= 1'b0;
            valid_pipe       <= '0;
            last_pipe        <= '0;
            wr_addr_out      <= '0;
            wr_data_out      <= '0;
            wr_en_out        <= 1'b0;
            rd_addr_out      <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            length_out       <= '0;
        end else begin
            wr_en_out        <= 1'b0;
            sample_valid_out <= 1'b0;

            if (discard) begin
                valid_pipe <= '0;
                last_pipe  <= '0;
            end else begin
                valid_pipe <= {valid_pipe[READ_LATENCY-1:0], tick_issue};
                last_pipe  <= {last_pipe[READ_LATENCY-1:0], last_issue};
            end

            if (valid_pipe[READ_LATENCY] && !discard) begin
                sample_out       <= rd_data_in;
                sample_valid_out <= 1'b1;
                if (last_pipe[READ_LATENCY]) begin
                    state <= IDLE;
                end
            end

            case (state)
                IDLE: begin
                    if (stop_in) begin
                        state <= IDLE;
                    end else if (record_in) begin
                        state      <= RECORD;
                        length_out <= '0;
                    end else if (play_in && (length_out != '0)) begin
                        state      <= PLAY;
                        rd_ptr     <= '0;
                        issue_done <= 1'b0;
                    end
                end
                RECORD: begin
                    if (stop_in) begin
                        state <= IDLE;
                    end else if (sample_valid_in) begin
                        wr_en_out   <= 1'b1;
                        wr_addr_out <= length_out[ADDR_WIDTH-1:0];
                        wr_data_out <= sample_in;
                        length_out  <= length_out + (ADDR_WIDTH+1)'(1);
                        if (length_out == LAST_WR_LEN) begin
                            state <= IDLE;
                        end
                    end
                end
                PLAY: begin
                    if (stop_in) begin
                        state <= IDLE;
                    end else if (tick_issue) begin
                        rd_addr_out <= rd_ptr;
                        if (is_last_idx) begin
                            if (loop_in) begin
                                rd_ptr <= '0;
                            end else begin
                                issue_done <= 1'b1;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/audio_buffer_ctrl.md
# audio_buffer_ctrl

Record/playback sequencer between the audio sample sources (UART receiver or SPI ADC capture) and the 8-bit PWM line-out stage. It owns both ports of the 8-bit audio BRAM. In RECORD it writes incoming samples through port B from address 0 upward and tracks the recorded length. In PLAY it reads port A once per 8 kHz tick, absorbs the BRAM read latency, and presents each sample with a one-cycle valid pulse for the PWM duty-cycle register.

## Interface

Parameters:
- WIDTH, 8, sample width in bits
- DEPTH, 40_000, BRAM depth in samples (5 s at 8 kHz)
- ADDR_WIDTH, $clog2(DEPTH), BRAM address width
- READ_LATENCY, 2, port A cycles from address to valid dout (output register enabled)

Ports:
- clk_in  in  1  system clock (100 MHz)
- rst_in  in  1  synchronous, active-high reset
- record_in  in  1  pulse: start recording
- play_in  in  1  pulse: start playback
- stop_in  in  1  pulse: abort current operation
- loop_in  in  1  level: restart playback at address 0 after the last sample
- sample_in  in  WIDTH  sample to record
- sample_valid_in  in  1  sample_in valid this cycle
- tick_in  in  1  8 kHz playback strobe, one cycle wide
- wr_addr_out  out  ADDR_WIDTH  port B address
- wr_data_out  out  WIDTH  port B write data
- wr_en_out  out  1  port B write enable
- rd_addr_out  out  ADDR_WIDTH  port A address
- rd_data_in  in  WIDTH  port A dout
- sample_out  out  WIDTH  playback sample for PWM
- sample_valid_out  out  1  one-cycle pulse when sample_out updates
- length_out  out  ADDR_WIDTH+1  number of recorded samples, 0..DEPTH
- state_out  out  2  0 IDLE, 1 RECORD, 2 PLAY
- busy_out  out  1  state_out != IDLE

## Operation

- Reset clears all registered outputs to 0: sample_out, sample_valid_out, wr_*, rd_addr_out and length_out. State goes to IDLE. The pointers and the read-latency pipeline are cleared.
- IDLE:
  - record_in: go to RECORD with write pointer and length_out set to 0.
  - play_in with length_out > 0: go to PLAY with read pointer set to 0.
  - play_in with length_out == 0: ignored.
  - Priority when pulses coincide: stop_in > record_in > play_in. stop_in in IDLE is a no-op and suppresses the others.
- RECORD:
  - Each sample_valid_in registers wr_en_out=1, wr_addr_out=pointer, wr_data_out=sample_in. The pointer and length_out then increment.
  - When the DEPTH-th sample is written, go to IDLE on the same edge. Later samples are ignored.
  - stop_in: go to IDLE and keep length_out. A sample_valid_in in the same cycle is not written.
  - record_in and play_in are ignored.
- PLAY:
  - On tick_in, rd_addr_out is registered with the read pointer, then the pointer advances.
  - A valid shift register of depth READ_LATENCY+1 tracks the in-flight read. On its output, sample_out <= rd_data_in and sample_valid_out pulses.
  - The tick that issues index length_out-1 samples loop_in:
    - loop_in=1: the pointer wraps to 0 and playback continues.
    - loop_in=0: further ticks are ignored. State goes to IDLE on the cycle the last sample_valid_out pulses.
  - stop_in: go to IDLE immediately. The in-flight read is discarded (no valid pulse) and sample_out holds its value.
  - sample_valid_in is ignored in PLAY (wr_en_out stays 0).
- wr_en_out is 0 outside the RECORD write cycle. sample_out holds its value between pulses.

## Timing

- Write: sample_valid_in at cycle T puts wr_en_out/wr_addr_out/wr_data_out at T+1. length_out updates at T+1.
- Read: tick_in at T puts rd_addr_out at T+1 and rd_data_in valid at T+1+READ_LATENCY. sample_out and sample_valid_out appear at T+2+READ_LATENCY, which is T+4 at the default latency.
- Ticks must be at least READ_LATENCY+2 cycles apart (8 kHz gives 12 500). Closer ticks are not required to work.
- record_in, play_in and stop_in act on the next edge. state_out and busy_out are registered.
- Reset asserted mid-PLAY or mid-RECORD takes effect on the next edge: no further write or valid pulse, and length_out becomes 0.

## Test plan

- Reset: hold rst_in 2 cycles, then release. Required: all outputs 0, state_out=0. play_in is ignored (length 0).
- Record: record_in, then 5 samples 0x10..0x14 spaced 3 cycles apart, then stop_in. Required: wr_en_out pulses at addresses 0..4 with data 0x10..0x14, each one cycle after its valid. length_out=5, state returns to IDLE.
- Play, no loop: loop_in=0, play_in, 6 ticks 20 cycles apart, BRAM model with 2-cycle latency. Required: sample_valid_out 4 cycles after each of the first 5 ticks with sample_out 0x10..0x14. The 6th tick produces nothing. State is IDLE on the 5th pulse.
- Play, loop: loop_in=1, 7 ticks. Required: output sequence 0x10,0x11,0x12,0x13,0x14,0x10,0x11 and state stays PLAY.
- Full: with DEPTH=8, record 10 samples. Required: writes only to addresses 0..7, length_out=8, state IDLE after the 8th write, samples 9–10 produce no write.
- Collisions: record_in and stop_in in the same IDLE cycle leaves the state IDLE. stop_in one cycle after a PLAY tick produces no sample_valid_out. Reset two cycles after a tick produces no valid pulse and length_out=0.
